compare_32b_arbiter: RTL and testbench

COMPARE_32B_ARBITER -- requirements
Module: compare_32b_arbiter

---
 rtl/compare_32b_arbiter.sv | 109 ++++++++++
 tb/tb_compare_32b_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/compare_32b_arbiter.sv
// Two-requester round-robin front end for a single 32-bit unsigned comparator.
// One compare in flight at a time: grant cycle, then a result cycle.

module Compare_32b_CA (
  output logic        A_gt_B,
  output logic        A_lt_B,
  output logic        A_eq_B,
  input  logic [31:0] A,
  input  logic [31:0] B
);
  assign A_gt_B = (A > B);
  assign A_lt_B = (A < B);
  assign A_eq_B = (A == B);
endmodule

module compare_32b_arbiter #(
  parameter bit FIRST_WINNER = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        res_id,
  output logic        A_gt_B,
  output logic        A_lt_B,
  output logic        A_eq_B,
  output logic [15:0] cmp_count
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic        last_id;
  logic [31:0] op_a, op_b;
  logic        grant_vld, grant_sel;
  logic        cmp_gt, cmp_lt, cmp_eq;

  Compare_32b_CA u_cmp (cmp_gt, cmp_lt, cmp_eq, op_a, op_b);

  assign busy = (state == BUSY);

  // Ties go to whichever requester did not win the previous grant.
  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant_vld = 1'b1;
          grant_sel = ~last_id;
        end else if (req0) begin
          grant_vld = 1'b1;
          grant_sel = 1'b0;
        end else if (req1) begin
          grant_vld = 1'b1;
          grant_sel = 1'b1;
        end
        if (grant_vld) state_nxt = BUSY;
      end
      BUSY:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done      <= 1'b0;
      res_id    <= 1'b0;
      A_gt_B    <= 1'b0;
      A_lt_B    <= 1'b0;
      A_eq_B    <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      cmp_count <= '0;
      last_id   <= ~FIRST_WINNER;
    end else begin
      state <= state_nxt;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done  <= 1'b0;
      if (grant_vld) begin
        op_a    <= grant_sel ? a1 : a0;
        op_b    <= grant_sel ? b1 : b0;
        res_id  <= grant_sel;
        last_id <= grant_sel;
        gnt0    <= ~grant_sel;
        gnt1    <= grant_sel;
      end
      if (state == BUSY) begin
        A_gt_B    <= cmp_gt;
        A_lt_B    <= cmp_lt;
        A_eq_B    <= cmp_eq;
        done      <= 1'b1;
        cmp_count <= cmp_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_compare_32b_arbiter.sv
// Directed bench for compare_32b_arbiter: latency, round-robin ties, reset abort,
// operand capture and counter wrap, all against hand-computed values.

module tb_compare_32b_arbiter;
  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, done, res_id, A_gt_B, A_lt_B, A_eq_B;
  logic [15:0] cmp_count;

  int n_chk  = 0;
  int n_fail = 0;

  compare_32b_arbiter #(.FIRST_WINNER(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .res_id(res_id),
    .A_gt_B(A_gt_B), .A_lt_B(A_lt_B), .A_eq_B(A_eq_B), .cmp_count(cmp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // {gnt0,gnt1,busy,done,res_id,gt,lt,eq}
  function automatic logic [7:0] flags();
    return {gnt0, gnt1, busy, done, res_id, A_gt_B, A_lt_B, A_eq_B};
  endfunction

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #2;
    do_reset();
    chk("reset_flags", flags(), 8'h00);
    chk("reset_count", cmp_count, 16'd0);

    // Idle with no requests stays quiet.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_flags", flags(), 8'h00);
    end

    // Single request: gnt at N+1, done at N+2.
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd0;
    tick();
    req0 = 1'b0;
    chk("single_gnt", flags(), 8'b1010_0000);
    tick();
    chk("single_done", flags(), 8'b0001_0100);
    chk("single_count", cmp_count, 16'd1);
    tick();
    chk("single_hold", flags(), 8'b0000_0100);

    // Held tie after reset: grants alternate 0,1,0,1.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    a0 = 32'd5; b0 = 32'd5; a1 = 32'd3; b1 = 32'd9;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_gnt", {gnt0, gnt1, busy, done}, (k % 2 == 0) ? 4'b1010 : 4'b0110);
      tick();
      chk("tie_done", flags(), (k % 2 == 0) ? 8'b0001_0001 : 8'b0001_1010);
    end
    chk("tie_count", cmp_count, 16'd4);
    req0 = 1'b0; req1 = 1'b0;

    // Back-to-back: req1 held 6 cycles, gnt1 every 2 cycles, never with done.
    do_reset();
    req1 = 1'b1; a1 = 32'd10; b1 = 32'd20;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("b2b_gnt1", gnt1, (k % 2 == 1) ? 1'b1 : 1'b0);
      chk("b2b_done", done, (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    req1 = 1'b0;
    chk("b2b_count", cmp_count, 16'd3);
    chk("b2b_lt", {A_gt_B, A_lt_B, A_eq_B}, 3'b010);

    // Reset during BUSY aborts the compare, then a tie goes to requester 0.
    tick();
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd2;
    tick();
    chk("abort_busy", {gnt0, busy}, 2'b11);
    req0 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_flags", flags(), 8'h00);
    chk("abort_count", cmp_count, 16'd0);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    chk("abort_tie", {gnt0, gnt1}, 2'b10);
    tick();
    chk("abort_tie_done", {done, res_id}, 2'b10);

    // Boundary operands; operands changed after grant must not leak in.
    req0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'd0;
    tick();
    req0 = 1'b0; a0 = 32'd0; b0 = 32'hFFFF_FFFF;
    tick();
    chk("max_gt", flags(), 8'b0001_0100);
    req1 = 1'b1; a1 = 32'd0; b1 = 32'hFFFF_FFFF;
    tick();
    req1 = 1'b0;
    chk("max_gnt1", {gnt0, gnt1}, 2'b01);
    tick();
    chk("max_lt", flags(), 8'b0001_1010);

    // Counter wrap: preload FFFF, one more compare wraps to 0.
    force dut.cmp_count = 16'hFFFF;
    #1;
    release dut.cmp_count;
    chk("wrap_preload", cmp_count, 16'hFFFF);
    req0 = 1'b1; a0 = 32'd4; b0 = 32'd4;
    tick();
    req0 = 1'b0;
    tick();
    chk("wrap_done", {done, A_eq_B}, 2'b11);
    chk("wrap_count", cmp_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Grants are exclusive and never coincide with done.
  always @(negedge clk) begin
    if (!rst && ((gnt0 && gnt1) || ((gnt0 || gnt1) && done)))
      chk("gnt_exclusive", {gnt0, gnt1, done}, 3'b000);
  end
endmodule
